// File: rtl/crc_pkg.sv
// Shared types and sizing helpers for the bit-serial CRC checker.
package crc_pkg;

  localparam int N_DEFAULT = 11;
  localparam int M_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One spare bit so the count of N+M-1 shift cycles never needs to wrap.
  function automatic int cnt_width(input int n, input int m);
    return $clog2(n + m) + 1;
  endfunction

endpackage

// File: rtl/crc_checker_if.sv
// Codeword in / result out handshake bundle for crc_checker.
interface crc_checker_if
  import crc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int M = M_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [N+M-2:0]   codeword;
  logic [M-1:0]     polynomial;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     data_out;
  logic [M-2:0]     syndrome;
  logic             crc_error;

  modport master (
    output in_valid, codeword, polynomial, out_ready,
    input  in_ready, out_valid, data_out, syndrome, crc_error
  );

  modport slave (
    input  in_valid, codeword, polynomial, out_ready,
    output in_ready, out_valid, data_out, syndrome, crc_error
  );
endinterface

// File: rtl/crc_serial_div.sv
// MSB-first serial polynomial divider: remainder register plus one-bit update.
module crc_serial_div
  import crc_pkg::*;
#(
  parameter int M = M_DEFAULT
) (
  input  logic         Clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  input  logic [M-2:0] poly,
  output logic [M-2:0] rem
);
  logic [M-2:0] rem_reg;
  logic [M-2:0] rem_next;

  // The bit leaving the top of the remainder decides whether the divisor is subtracted.
  generate
    for (genvar gi = 0; gi < M - 1; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign rem_next[gi] = bit_in ^ (rem_reg[M-2] & poly[gi]);
      end else begin : g_upper
        assign rem_next[gi] = rem_reg[gi-1] ^ (rem_reg[M-2] & poly[gi]);
      end
    end
  endgenerate

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_reg <= '0;
    end else if (clr) begin
      rem_reg <= '0;
    end else if (en) begin
      rem_reg <= rem_next;
    end
  end

  assign rem = rem_reg;

endmodule

// File: rtl/crc_checker.sv
// Bit-serial CRC checker for {data, crc} codewords; one codeword bit per clock.
// Optional saturating error counter enabled by defining CRC_ERR_COUNT_EN.
module crc_checker
  import crc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int M = M_DEFAULT
) (
  input  logic          Clk,
  input  logic          reset_n,
  crc_checker_if.slave  bus
`ifdef CRC_ERR_COUNT_EN
  ,
  output logic [15:0]   err_count
`endif
);
  localparam int W  = N + M - 1;
  localparam int CW = cnt_width(N, M);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t state_reg, state_next;

  logic [W-1:0]  sreg_reg;
  logic [M-2:0]  preg_reg;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  data_pend_reg;
  logic [N-1:0]  data_hold_reg;
  logic [M-2:0]  syn_hold_reg;
  logic [M-2:0]  rem;

  logic in_ready_s, out_valid_s;
  logic accept, shift_en, consume;
  logic [N-1:0]  data_s;
  logic [M-2:0]  syn_s;
  logic          unused_poly_msb;

  assign unused_poly_msb = bus.polynomial[M-1];

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)       state_next = SHIFT;
      SHIFT:   if (cnt_reg == LAST)    state_next = DONE;
      DONE:    if (bus.out_ready)      state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_s  = (state_reg == IDLE);
    out_valid_s = (state_reg == DONE);
    accept      = in_ready_s && bus.in_valid;
    shift_en    = (state_reg == SHIFT);
    consume     = out_valid_s && bus.out_ready;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_reg      <= '0;
      preg_reg      <= '0;
      cnt_reg       <= '0;
      data_pend_reg <= '0;
      data_hold_reg <= '0;
      syn_hold_reg  <= '0;
    end else begin
      if (accept) begin
        sreg_reg      <= bus.codeword;
        preg_reg      <= bus.polynomial[M-2:0];
        cnt_reg       <= '0;
        data_pend_reg <= bus.codeword[W-1:M-1];
      end else if (shift_en) begin
        sreg_reg <= {sreg_reg[W-2:0], 1'b0};
        cnt_reg  <= cnt_reg + CW'(1);
      end
      // Results stay visible in IDLE/SHIFT until the next frame reaches DONE.
      if (consume) begin
        data_hold_reg <= data_pend_reg;
        syn_hold_reg  <= rem;
      end
    end
  end

  crc_serial_div #(.M(M)) u_div (
    .Clk     (Clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (shift_en),
    .bit_in  (sreg_reg[W-1]),
    .poly    (preg_reg),
    .rem     (rem)
  );

  // In DONE the divider and pending data already hold the final, frozen result.
  assign data_s = out_valid_s ? data_pend_reg : data_hold_reg;
  assign syn_s  = out_valid_s ? rem : syn_hold_reg;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.data_out  = data_s;
  assign bus.syndrome  = syn_s;
  assign bus.crc_error = |syn_s;

`ifdef CRC_ERR_COUNT_EN
  logic [15:0] err_count_reg;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_reg <= '0;
    end else if (consume && (|syn_s) && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// Self-checking bench for crc_checker: fixed vectors, corner sequences, random frames vs long-division model.
module tb_crc_checker;
  localparam int N = 11;
  localparam int M = 5;
  localparam int W = N + M - 1;

  logic Clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  crc_checker_if #(.N(N), .M(M)) bus ();

`ifdef CRC_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  crc_checker #(.N(N), .M(M)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef CRC_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0]   cw;
    logic [M-1:0]   poly;
    logic [N-1:0]   exp_data;
    logic [M-2:0]   exp_syn;
    logic           exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: polynomial long division of the codeword by {1, poly[M-2:0]}.
  function automatic logic [M-2:0] model_rem(input logic [W-1:0] cw, input logic [M-1:0] poly);
    logic [W-1:0] r;
    logic [W-1:0] g;
    r = cw;
    g = W'({1'b1, poly[M-2:0]});
    for (int i = W - 1; i >= M - 1; i--) begin
      if (r[i]) r = r ^ (g << (i - (M - 1)));
    end
    return r[M-2:0];
  endfunction

  task automatic send_frame(input logic [W-1:0] cw, input logic [M-1:0] p);
    int guard;
    guard = 0;
    @(negedge Clk);
    while (!bus.in_ready && guard < 60) begin
      @(negedge Clk);
      guard++;
    end
    chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.codeword   = cw;
    bus.polynomial = p;
    bus.in_valid   = 1'b1;
    @(posedge Clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.codeword   = W'($urandom);
    bus.polynomial = M'($urandom);
  endtask

  task automatic wait_result();
    int lat;
    lat = 0;
    do begin
      @(posedge Clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 100);
    chk("latency", 32'(lat), 32'(W));
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_after_consume", 32'(bus.out_valid), 32'd0);
    chk("in_ready_after_consume", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_frame(input string name, input logic [W-1:0] cw, input logic [M-1:0] p,
                          input logic [N-1:0] ed, input logic [M-2:0] es, input logic ee);
    send_frame(cw, p);
    wait_result();
    chk({name, "_data"}, 32'(bus.data_out), 32'(ed));
    chk({name, "_syndrome"}, 32'(bus.syndrome), 32'(es));
    chk({name, "_crc_error"}, 32'(bus.crc_error), 32'(ee));
    $display("frame %s cw=%h poly=%h data=%h syn=%h err=%b", name, cw, p,
             bus.data_out, bus.syndrome, bus.crc_error);
    consume();
    chk({name, "_syn_held_idle"}, 32'(bus.syndrome), 32'(es));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rd;
    logic [M-1:0] rp;
    logic [W-1:0] rcw;
    logic [M-2:0] rs;
    int bad;
    int stray;

    vecs[0] = '{15'b00000000001_0011, 5'b10011, 11'd1,            4'b0000, 1'b0};
    vecs[1] = '{15'b10000000000_1001, 5'b10011, 11'b10000000000,  4'b0000, 1'b0};
    vecs[2] = '{15'b00000000001_0010, 5'b10011, 11'd1,            4'b0001, 1'b1};
    vecs[3] = '{15'b00000000000_1001, 5'b10011, 11'd0,            4'b1001, 1'b1};
    vecs[4] = '{15'b00000000001_0011, 5'b00011, 11'd1,            4'b0000, 1'b0};
    vecs[5] = '{15'b10110011010_0110, 5'b00000, 11'b10110011010,  4'b0110, 1'b1};

    bus.in_valid   = 1'b0;
    bus.codeword   = '0;
    bus.polynomial = '0;
    bus.out_ready  = 1'b0;
    reset_n        = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_data_out", 32'(bus.data_out), 32'd0);
    chk("reset_syndrome", 32'(bus.syndrome), 32'd0);
    chk("reset_crc_error", 32'(bus.crc_error), 32'd0);
    @(negedge Clk);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_frame($sformatf("vec%0d", i), vecs[i].cw, vecs[i].poly,
               vecs[i].exp_data, vecs[i].exp_syn, vecs[i].exp_err);
    end

    // Reset five cycles into a frame: abort with no result.
    send_frame(15'b00000000001_0010, 5'b10011);
    repeat (5) @(posedge Clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_syndrome", 32'(bus.syndrome), 32'd0);
    chk("midreset_data_out", 32'(bus.data_out), 32'd0);
    @(negedge Clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (25) begin
      @(posedge Clk);
      #1;
      if (bus.out_valid) stray++;
    end
    chk("midreset_stray_out_valid", 32'(stray), 32'd0);
    chk("midreset_syndrome_after", 32'(bus.syndrome), 32'd0);
    $display("frame midreset aborted stray=%0d", stray);

    // in_valid held through SHIFT and DONE must be ignored; result held while out_ready=0.
    send_frame(15'b00000000001_0010, 5'b10011);
    bus.in_valid   = 1'b1;
    bus.codeword   = 15'h7FFF;
    bus.polynomial = 5'b11111;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge Clk);
      #1;
      if (bus.in_ready) bad++;
      if (bus.out_valid) break;
    end
    chk("hs_in_ready_shift", 32'(bad), 32'd0);
    chk("hs_out_valid", 32'(bus.out_valid), 32'd1);
    bad = 0;
    repeat (10) begin
      @(posedge Clk);
      #1;
      if (!bus.out_valid || bus.in_ready || bus.data_out != 11'd1 || bus.syndrome != 4'b0001)
        bad++;
    end
    chk("hs_hold_stable", 32'(bad), 32'd0);
    chk("hs_syndrome", 32'(bus.syndrome), 32'h1);
    $display("frame handshake data=%h syn=%h err=%b", bus.data_out, bus.syndrome, bus.crc_error);
    bus.in_valid = 1'b0;
    consume();
    stray = 0;
    repeat (20) begin
      @(posedge Clk);
      #1;
      if (bus.out_valid || !bus.in_ready) stray++;
    end
    chk("hs_extra_ignored", 32'(stray), 32'd0);

    for (int i = 0; i < 40; i++) begin
      rd = N'($urandom);
      rp = M'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rcw = {rd, model_rem(W'(rd) << (M - 1), rp)};
      end else begin
        rcw = W'($urandom);
        rd  = rcw[W-1:M-1];
      end
      rs = model_rem(rcw, rp);
      do_frame($sformatf("rnd%0d", i), rcw, rp, rd, rs, |rs);
    end

`ifdef CRC_ERR_COUNT_EN
    begin
      logic [15:0] e0;
      e0 = err_count;
      do_frame("ec_bad0", 15'b00000000001_0010, 5'b10011, 11'd1, 4'b0001, 1'b1);
      do_frame("ec_bad1", 15'b00000000000_1001, 5'b10011, 11'd0, 4'b1001, 1'b1);
      do_frame("ec_bad2", 15'b10110011010_0110, 5'b00000, 11'b10110011010, 4'b0110, 1'b1);
      do_frame("ec_good0", 15'b00000000001_0011, 5'b10011, 11'd1, 4'b0000, 1'b0);
      do_frame("ec_good1", 15'b10000000000_1001, 5'b10011, 11'b10000000000, 4'b0000, 1'b0);
      chk("err_count_delta", 32'(err_count - e0), 32'd3);
      @(negedge Clk);
      force dut.err_count_reg = 16'hFFFE;
      #1;
      release dut.err_count_reg;
      do_frame("ec_sat0", 15'b00000000001_0010, 5'b10011, 11'd1, 4'b0001, 1'b1);
      chk("err_count_ffff", 32'(err_count), 32'hFFFF);
      do_frame("ec_sat1", 15'b00000000001_0010, 5'b10011, 11'd1, 4'b0001, 1'b1);
      chk("err_count_saturated", 32'(err_count), 32'hFFFF);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
